sieve_reader: RTL and testbench

- Read-side companion to the sieve engine.
- Once the sieve reports done, this block scans the sieve's block RAM from address 2 to the top address.
- Every unmarked entry (value 0) is a prime; its address is emitted on a valid/ready stream.
- Sits on the same blockram port as the sieve. The top level muxes addr/wr to this block whenever the sieve is not busy.

---
 rtl/sieve_pkg.sv | 19 +
 rtl/sieve_skid_fifo.sv | 53 +++++
 rtl/sieve_reader.sv | 119 +++++++++++
 tb/tb_sieve_reader.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sieve_pkg.sv
// Definitions shared by the sieve engine and the sieve reader:
// FSM states, first scanned candidate and the composite-marking rule.
package sieve_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SCAN,
    DRAIN,
    FIN
  } sieve_state_e;

  localparam int unsigned FIRST_CANDIDATE = 2;

  // Any nonzero RAM entry marks the address as composite.
  function automatic logic is_composite(input logic [63:0] entry);
    return entry != '0;
  endfunction

endpackage

// File: rtl/sieve_skid_fifo.sv
// Two-entry FIFO carrying prime addresses to the output stream.
// Head, fill level and flags come straight from registers.
module sieve_skid_fifo #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] head_q, head_d;
  logic [W-1:0] tail_q, tail_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         do_push, do_pop;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    do_pop  = pop_i && (cnt_q != 2'd0);
    do_push = push_i && ((cnt_q != 2'd2) || do_pop);
    if (do_pop) head_d = tail_q;
    // A push lands in the head slot whenever the FIFO is empty after the pop.
    if (do_push) begin
      if ((cnt_q == 2'd0) || ((cnt_q == 2'd1) && do_pop)) head_d = din_i;
      else tail_d = din_i;
    end
    cnt_d = cnt_q + 2'(do_push) - 2'(do_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout_o  = head_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/sieve_reader.sv
// Scans the sieve block RAM after the sieve finishes and streams every
// unmarked address (a prime) out on a valid/ready interface.
module sieve_reader
  import sieve_pkg::*;
#(
  parameter int unsigned DATA = 8,
  parameter int unsigned ADDR = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [ADDR-1:0] addr,
  output logic            wr,
  input  logic [DATA-1:0] din,
  output logic [ADDR-1:0] prime,
  output logic            valid,
  input  logic            ready,
  output logic [ADDR:0]   count,
  output logic            busy,
  output logic            done
);

  localparam int unsigned CW = ADDR + 1;

  sieve_state_e    state_q, state_d;
  logic [ADDR-1:0] next_q, next_d;
  logic [ADDR-1:0] addr_q, addr_d;
  logic            inflight_q, inflight_d;
  logic [ADDR:0]   count_q, count_d;
  logic            done_q, done_d;

  logic            issue, push, pop;
  logic            fifo_full, fifo_empty;
  logic [1:0]      fifo_cnt;
  logic [2:0]      occ;

  sieve_skid_fifo #(.W(ADDR)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (addr_q),
    .pop_i   (pop),
    .dout_o  (prime),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_cnt)
  );

  assign valid = !fifo_empty;
  assign pop   = valid && ready;
  // addr_q always holds the address of the read currently in flight.
  assign push  = inflight_q && !is_composite(64'(din));
  // An accepted head frees its slot this cycle, keeping one prime per cycle.
  assign occ   = 3'(fifo_cnt) + 3'(inflight_q) - 3'(pop);

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    addr_d  = addr_q;
    count_d = count_q + CW'(pop);
    done_d  = done_q;
    issue   = 1'b0;
    busy    = 1'b0;
    unique case (state_q)
      IDLE, FIN: begin
        if (start) begin
          state_d = SCAN;
          next_d  = ADDR'(FIRST_CANDIDATE);
          count_d = '0;
          done_d  = 1'b0;
        end else if (state_q == FIN) begin
          state_d = IDLE;
        end
      end
      SCAN: begin
        busy = 1'b1;
        if ((occ < 3'd2) && (!fifo_full || pop)) begin
          issue  = 1'b1;
          addr_d = next_q;
          if (next_q == '1) state_d = DRAIN;
          else next_d = next_q + 1'b1;
        end
      end
      DRAIN: begin
        busy = 1'b1;
        if (!inflight_q && fifo_empty) begin
          state_d = FIN;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    inflight_d = issue;
    addr       = addr_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      next_q     <= '0;
      addr_q     <= '0;
      inflight_q <= 1'b0;
      count_q    <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      next_q     <= next_d;
      addr_q     <= addr_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      done_q     <= done_d;
    end
  end

  assign wr    = 1'b0;
  assign count = count_q;
  assign done  = done_q;

endmodule

// File: tb/tb_sieve_reader.sv
// Bench for sieve_reader: RAM model plus a reference list of expected primes
// built directly from the RAM contents.
module tb_sieve_reader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] addr;
  logic       wr;
  logic [7:0] din;
  logic [7:0] prime;
  logic       valid;
  logic       ready;
  logic [8:0] count;
  logic       busy;
  logic       done;

  logic [7:0] mem [256];
  int unsigned exp_q[$];
  int unsigned got_q[$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) din <= mem[addr];

  sieve_reader #(.DATA(8), .ADDR(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .addr  (addr),
    .wr    (wr),
    .din   (din),
    .prime (prime),
    .valid (valid),
    .ready (ready),
    .count (count),
    .busy  (busy),
    .done  (done)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_wr"}, wr, 0);
    chk({tag, "_valid"}, valid, 0);
    chk({tag, "_prime"}, prime, 0);
    chk({tag, "_count"}, count, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic fill_sieve();
    for (int a = 0; a < 256; a++) mem[a] = 8'h00;
    mem[0] = 8'h01;
    mem[1] = 8'h01;
    for (int i = 2; i * i < 256; i++)
      if (mem[i] == 8'h00)
        for (int j = i * i; j < 256; j += i) mem[j] = 8'($urandom_range(1, 255));
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int a = 0; a < 256; a++) mem[a] = v;
  endtask

  task automatic fill_random();
    for (int a = 0; a < 256; a++)
      mem[a] = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
  endtask

  // mode: 0 ready always high, 1 ready low on cycles 3..12, 2 random ready.
  task automatic run_scan(input int mode, input int rst_after, input int poke_at, input bit tp);
    int  idx = 0;
    int  first_v = -1;
    int  last_acc = -1;
    bit  prev_stall = 1'b0;
    logic [7:0] prev_prime = '0;
    bit  prev_busy = 1'b0;
    bit  finished = 1'b0;
    bit  aborted = 1'b0;

    exp_q.delete();
    got_q.delete();
    for (int a = 2; a < 256; a++) if (mem[a] == 8'h00) exp_q.push_back(a);

    @(negedge clk);
    start = 1'b1;
    ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("start_done_clr", done, 0);
    chk("start_count_clr", count, 0);
    chk("start_busy", busy, 1);
    chk("wr_low", wr, 0);

    for (int s = 0; s < 3000 && !finished; s++) begin
      start = 1'b0;
      case (mode)
        1:       ready = !(s >= 3 && s <= 12);
        2:       ready = ($urandom_range(0, 3) != 0);
        default: ready = 1'b1;
      endcase
      if (s == poke_at) begin
        chk("poke_while_busy", busy, 1);
        start = 1'b1;
      end
      #1;
      if (prev_stall) begin
        chk("hold_valid", valid, 1);
        chk("hold_prime", prime, prev_prime);
      end
      if (mode == 1 && (s == 8 || s == 12)) chk("stall_addr", addr, 4);
      if (valid) begin
        if (first_v < 0) begin
          first_v = s;
          if (exp_q.size() > 0 && exp_q[0] == 2) chk("first_latency", s, 2);
        end
        chk("count_run", count, idx);
        if (idx < exp_q.size()) chk("prime", prime, exp_q[idx]);
        else chk("extra_valid", valid, 0);
        if (ready) begin
          got_q.push_back(prime);
          if (tp && idx > 0) chk("throughput", s - last_acc, 1);
          idx++;
          last_acc = s;
        end
      end
      prev_stall = valid && !ready;
      prev_prime = prime;
      if (done) begin
        finished = 1'b1;
        chk("done_busy_low", busy, 0);
        chk("done_after_busy", prev_busy, 1);
        if (tp) chk("done_latency", s - last_acc, 2);
      end
      prev_busy = busy;
      if (!finished && rst_after > 0 && idx == rst_after) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset_values("midscan_rst");
        for (int k = 0; k < 5; k++) begin
          @(negedge clk);
          #1;
          chk("post_rst_valid", valid, 0);
          chk("post_rst_busy", busy, 0);
        end
        finished = 1'b1;
        aborted  = 1'b1;
      end
      if (!finished) @(negedge clk);
    end

    if (!aborted) begin
      if (!finished) chk("scan_timeout", 0, 1);
      chk("final_count", count, exp_q.size());
      chk("final_accepts", idx, exp_q.size());
      repeat (3) @(negedge clk);
      #1;
      chk("done_held", done, 1);
      chk("idle_busy", busy, 0);
      chk("idle_valid", valid, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    ready = 1'b0;
    fill_const(8'h00);
    repeat (3) @(negedge clk);
    #1;
    chk_reset_values("reset");
    rst = 1'b0;

    // Sieve-filled memory, ready high.
    fill_sieve();
    run_scan(0, 0, -1, 1'b0);
    chk("n_primes", got_q.size(), 54);
    chk("dut_count54", count, 54);
    if (got_q.size() >= 5) begin
      chk("p0", got_q[0], 2);
      chk("p1", got_q[1], 3);
      chk("p2", got_q[2], 5);
      chk("p3", got_q[3], 7);
      chk("p4", got_q[4], 11);
      chk("p_last", got_q[got_q.size() - 1], 251);
    end

    // All-zero memory: every address is emitted, one per cycle.
    fill_const(8'h00);
    run_scan(0, 0, -1, 1'b1);
    chk("zero_count", count, 254);

    // All-zero memory with a consumer stall.
    run_scan(1, 0, -1, 1'b0);
    chk("stall_count", count, 254);

    // All-composite memory: nothing emitted.
    fill_const(8'hFF);
    run_scan(0, 0, -1, 1'b0);
    chk("ff_count", count, 0);

    // Reset after 20 accepts, then a fresh scan.
    fill_sieve();
    run_scan(0, 20, -1, 1'b0);
    run_scan(0, 0, -1, 1'b0);
    chk("rescan_count", count, 54);
    if (got_q.size() > 0) chk("rescan_first", got_q[0], 2);

    // Start while busy is ignored; start while done rescans.
    run_scan(0, 0, 30, 1'b0);
    chk("poke_count", count, 54);
    run_scan(2, 0, -1, 1'b0);
    chk("redo_count", count, 54);

    // Random memory contents with random backpressure.
    for (int r = 0; r < 3; r++) begin
      fill_random();
      run_scan(2, 0, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
